// File: rtl/rv_ifetch_ctrl.sv
// rv_ifetch_ctrl: sequential instruction fetch with in-order buffering, credit-based issue and redirect flush.
// Build option RV_IFETCH_BYPASS_EN: a response arriving at an empty buffer drives instr_* in the same cycle.
module rv_ifetch_ctrl #(
  parameter int unsigned      MXLEN      = 32,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter int unsigned      MAX_OUTST  = 2,
  parameter logic [MXLEN-1:0] RESET_PC   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [MXLEN-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [MXLEN-1:0] redirect_pc_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [MXLEN-1:0] instr_pc_o,
  input  logic             instr_ready_i
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C   = CW'(MAX_OUTST);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTST - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [MXLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    kill_q, kill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]    tag_rd_q, tag_rd_d;
  logic [TW-1:0]    tag_wr_q, tag_wr_d;

  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [MXLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [MXLEN-1:0] tag_pc_q     [MAX_OUTST];

  logic             fifo_empty;
  logic             req;
  logic             fire;
  logic             resp_keep;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [MXLEN-1:0] resp_pc;

  // Fetch addresses are word aligned, so the low redirect bits are discarded.
  logic [1:0] unused_pc_lsb;
  assign unused_pc_lsb = redirect_pc_i[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    outst_d    = outst_q;
    kill_d     = kill_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;

    fifo_empty = (count_q == '0);
    resp_pc    = tag_pc_q[tag_rd_q];

    // Credits cover buffered plus in-flight words, so a push can never find the buffer full.
    req        = (state_q != ST_BOOT) && ((count_q + outst_q) < DEPTH_C) && (outst_q < MAXO_C);
    fire       = req && imem_gnt_i;
    resp_keep  = imem_rvalid_i && (kill_q == '0) && !redirect_i;

`ifdef RV_IFETCH_BYPASS_EN
    bypass     = resp_keep && fifo_empty;
`else
    bypass     = 1'b0;
`endif

    push       = resp_keep && !(bypass && instr_ready_i);
    pop        = !fifo_empty && instr_ready_i && !redirect_i;

    outst_d    = outst_q + CW'(fire) - CW'(imem_rvalid_i);

    if (fire) begin
      tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
    end
    if (imem_rvalid_i) begin
      tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);
    end

    if (redirect_i) begin
      // Everything still in flight after this edge, including a same-cycle grant, is stale.
      kill_d   = outst_q + CW'(fire) - CW'(imem_rvalid_i);
      pc_d     = {redirect_pc_i[MXLEN-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (imem_rvalid_i && (kill_q != '0)) begin
        kill_d = kill_q - ONE_C;
      end
      if (fire) begin
        pc_d = pc_q + MXLEN'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect_i && (kill_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (kill_d == '0) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      kill_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Storage needs no reset: pointers and count decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= resp_pc;
    end
    if (fire) begin
      tag_pc_q[tag_wr_q] <= pc_q;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !fifo_empty || bypass;
  assign instr_o       = bypass     ? imem_rdata_i :
                         fifo_empty ? 32'h0        : fifo_instr_q[rd_ptr_q];
  assign instr_pc_o    = bypass     ? resp_pc      :
                         fifo_empty ? '0           : fifo_pc_q[rd_ptr_q];

endmodule
